// File: rtl/spi_request_arbiter_if.sv
// spi_request_arbiter_if: requester-side request/response signals plus the Avalon-MM master bus of spi_request_arbiter
interface spi_request_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ*18-1:0] req_cfg;
  logic [NUM_REQ*32-1:0] req_tx;
  logic [NUM_REQ-1:0] req_ack;
  logic [NUM_REQ-1:0] rsp_valid;
  logic [31:0] rsp_rx;
  logic rsp_err;
  logic busy;
  logic m_cs;
  logic [2:0] m_addr;
  logic m_write;
  logic [31:0] m_writedata;
  logic m_read;
  logic [31:0] m_readdata;
  modport slave (
    input req_valid, req_cfg, req_tx, m_readdata,
    output req_ack, rsp_valid, rsp_rx, rsp_err, busy, m_cs, m_addr, m_write, m_writedata, m_read
  );
  modport master (
    output req_valid, req_cfg, req_tx, m_readdata,
    input req_ack, rsp_valid, rsp_rx, rsp_err, busy, m_cs, m_addr, m_write, m_writedata, m_read
  );
endinterface

// File: rtl/spi_request_arbiter.sv
// spi_request_arbiter: round-robin sharing of one controller_spi among NUM_REQ requesters; ports avmm_clk, avmm_reset_n and bus (slave: req_*/rsp_*/busy plus Avalon-MM m_*)
module spi_request_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int POLL_LIMIT = 4096
) (
  input logic avmm_clk,
  input logic avmm_reset_n,
  spi_request_arbiter_if.slave bus
);
  localparam int SW = $clog2(NUM_REQ);
  localparam int CW = $clog2(POLL_LIMIT + 1);
  typedef enum logic [3:0] {
    S_IDLE, S_WR_CFG, S_WR_TX, S_WR_START, S_POLL, S_POLL_WAIT, S_RD_RX, S_RD_WAIT, S_DONE
  } state_t;
  state_t r_state;
  logic [SW-1:0] r_ptr, r_sel, w_sel;
  logic [31:0] r_tx, r_rx, r_wdata;
  logic [CW-1:0] r_cnt;
  logic [NUM_REQ-1:0] r_ack, r_rsp_valid;
  logic r_err, r_busy, r_cs, r_write, r_read;
  logic [2:0] r_addr;
  always_comb begin
    w_sel = r_ptr;
    for (int k = NUM_REQ; k >= 1; k--)
      if (bus.req_valid[(int'(r_ptr) + k) % NUM_REQ]) w_sel = SW'((int'(r_ptr) + k) % NUM_REQ);
  end
  always_ff @(posedge avmm_clk or negedge avmm_reset_n) begin
    if (!avmm_reset_n) begin
      r_state <= S_IDLE;
      r_ptr <= SW'(NUM_REQ - 1);
      r_sel <= '0;
      r_tx <= '0;
      r_rx <= '0;
      r_cnt <= '0;
      r_ack <= '0;
      r_rsp_valid <= '0;
      r_err <= 1'b0;
      r_busy <= 1'b0;
      r_cs <= 1'b0;
      r_write <= 1'b0;
      r_read <= 1'b0;
      r_addr <= '0;
      r_wdata <= '0;
    end else begin
      r_ack <= '0;
      r_rsp_valid <= '0;
      r_err <= 1'b0;
      r_cs <= 1'b0;
      r_write <= 1'b0;
      r_read <= 1'b0;
      r_addr <= '0;
      r_wdata <= '0;
      case (r_state)
        S_IDLE: if (|bus.req_valid) begin
          r_state <= S_WR_CFG;
          r_sel <= w_sel;
          r_busy <= 1'b1;
          r_cnt <= '0;
          r_ack[w_sel] <= 1'b1;
          r_tx <= bus.req_tx[w_sel*32 +: 32];
          r_cs <= 1'b1;
          r_write <= 1'b1;
          r_addr <= 3'd1;
          r_wdata <= {14'b0, bus.req_cfg[w_sel*18+8 +: 10], 2'b0, bus.req_cfg[w_sel*18 +: 6]};
        end
        S_WR_CFG: begin
          r_state <= S_WR_TX;
          r_cs <= 1'b1;
          r_write <= 1'b1;
          r_addr <= 3'd2;
          r_wdata <= r_tx;
        end
        S_WR_TX: begin
          r_state <= S_WR_START;
          r_cs <= 1'b1;
          r_write <= 1'b1;
          r_wdata <= 32'h1;
        end
        S_WR_START: begin
          r_state <= S_POLL;
          r_cs <= 1'b1;
          r_read <= 1'b1;
        end
        S_POLL: begin
          r_state <= S_POLL_WAIT;
          r_cnt <= r_cnt + CW'(1);
        end
        S_POLL_WAIT: if (!bus.m_readdata[1]) begin
          r_state <= S_RD_RX;
          r_cs <= 1'b1;
          r_read <= 1'b1;
          r_addr <= 3'd3;
        end else if (r_cnt < CW'(POLL_LIMIT)) begin
          r_state <= S_POLL;
          r_cs <= 1'b1;
          r_read <= 1'b1;
        end else begin
          r_state <= S_DONE;
          r_rx <= '0;
          r_rsp_valid[r_sel] <= 1'b1;
          r_err <= 1'b1;
        end
        S_RD_RX: r_state <= S_RD_WAIT;
        S_RD_WAIT: begin
          r_state <= S_DONE;
          r_rx <= bus.m_readdata;
          r_rsp_valid[r_sel] <= 1'b1;
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_ptr <= r_sel;
          r_busy <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
  assign bus.req_ack = r_ack;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rx = r_rx;
  assign bus.rsp_err = r_err;
  assign bus.busy = r_busy;
  assign bus.m_cs = r_cs;
  assign bus.m_addr = r_addr;
  assign bus.m_write = r_write;
  assign bus.m_writedata = r_wdata;
  assign bus.m_read = r_read;
endmodule

// File: tb/tb_spi_request_arbiter.sv
// tb_spi_request_arbiter: directed tests with a transaction-level model and a loopback controller_spi stand-in
module tb_spi_request_arbiter;
  localparam int N = 4;
  localparam int PL = 3;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  spi_request_arbiter_if #(.NUM_REQ(N)) bus ();
  spi_request_arbiter #(.NUM_REQ(N), .POLL_LIMIT(PL)) dut (.avmm_clk(clk), .avmm_reset_n(rst_n), .bus(bus));
  int total = 0;
  int bad = 0;
  int nbusy = 0;
  logic [N-1:0] persist = '0;
  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  function automatic logic [31:0] loopback(logic [17:0] cfg, logic [31:0] tx);
    int n;
    n = int'(cfg[5:0]) + 1;
    return (n >= 32) ? tx : tx >> (32 - n);
  endfunction
  function automatic int rr(logic [N-1:0] r, int ptr);
    for (int k = 1; k <= N; k++)
      if (r[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction
  logic [31:0] c_cfg, c_tx;
  int c_polls;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_cfg <= '0;
      c_tx <= '0;
      c_polls <= 0;
      bus.m_readdata <= '1;
    end else begin
      bus.m_readdata <= '1;
      if (bus.m_write && bus.m_addr == 3'd1) c_cfg <= bus.m_writedata;
      if (bus.m_write && bus.m_addr == 3'd2) c_tx <= bus.m_writedata;
      if (bus.m_write && bus.m_addr == 3'd0) c_polls <= 0;
      if (bus.m_read && bus.m_addr == 3'd0) begin
        bus.m_readdata <= (c_polls < nbusy) ? 32'h2 : 32'h0;
        c_polls <= c_polls + 1;
      end
      if (bus.m_read && bus.m_addr == 3'd3) bus.m_readdata <= loopback(c_cfg[17:0], c_tx);
    end
  end
  int cyc = 0, a = 0, p = 0, done_off = 0, ptr = N - 1, sel = 0, g = 0, off = 0;
  bit act = 0, to = 0, idle_l = 1;
  logic [N-1:0] req_l = '0, e_ack, e_rv;
  logic [N*18-1:0] cfgv_l = '0;
  logic [N*32-1:0] txv_l = '0;
  logic [17:0] t_cfg;
  logic [31:0] t_tx, m_rx = '0, e_d;
  logic [2:0] e_a;
  logic e_w, e_r;
  int grants[$];
  int ack_q[$];
  logic [35:0] ops[$];
  int ack_cyc[N], rsp_cyc[N], rsp_n[N];
  logic err_obs[N];
  initial for (int i = 0; i < N; i++) begin
    ack_cyc[i] = 0;
    rsp_cyc[i] = 0;
    rsp_n[i] = 0;
    err_obs[i] = 1'b0;
  end
  always @(negedge clk) begin
    if (!rst_n) begin
      act = 0;
      idle_l = 1;
      req_l = '0;
      ptr = N - 1;
      m_rx = '0;
      check("reset_outs", {bus.req_ack, bus.rsp_valid, bus.rsp_rx, bus.rsp_err, bus.busy, bus.m_cs, bus.m_addr, bus.m_write, bus.m_read, bus.m_writedata}, '0);
    end else begin
      cyc++;
      e_ack = '0;
      if (idle_l && req_l != '0) begin
        g = rr(req_l, ptr);
        e_ack[g] = 1'b1;
        act = 1;
        a = cyc;
        sel = g;
        t_cfg = cfgv_l[g*18 +: 18];
        t_tx = txv_l[g*32 +: 32];
        to = (nbusy >= PL);
        p = to ? PL : nbusy + 1;
        done_off = to ? 3 + 2 * p : 5 + 2 * p;
      end
      off = cyc - a;
      e_w = act && off <= 2;
      e_r = act && ((off >= 3 && off < 3 + 2 * p && (off - 3) % 2 == 0) || (!to && off == 3 + 2 * p));
      e_a = '0;
      e_d = '0;
      if (e_w) begin
        e_a = (off == 0) ? 3'd1 : (off == 1) ? 3'd2 : 3'd0;
        e_d = (off == 0) ? {14'b0, t_cfg[17:8], 2'b0, t_cfg[5:0]} : (off == 1) ? t_tx : 32'h1;
      end
      if (act && !to && off == 3 + 2 * p) e_a = 3'd3;
      e_rv = '0;
      if (act && off == done_off) begin
        e_rv[sel] = 1'b1;
        m_rx = to ? 32'h0 : loopback(t_cfg, t_tx);
      end
      check("req_ack", bus.req_ack, e_ack);
      check("rsp_valid", bus.rsp_valid, e_rv);
      if (e_rv != '0) check("rsp_err", bus.rsp_err, to);
      check("rsp_rx", bus.rsp_rx, m_rx);
      check("busy", bus.busy, act);
      check("m_write", bus.m_write, e_w);
      check("m_read", bus.m_read, e_r);
      check("m_cs", bus.m_cs, e_w | e_r);
      check("m_addr", bus.m_addr, e_a);
      check("m_writedata", bus.m_writedata, e_d);
      for (int i = 0; i < N; i++) begin
        if (bus.req_ack[i]) begin
          grants.push_back(i);
          ack_q.push_back(cyc);
          ack_cyc[i] = cyc;
        end
        if (bus.rsp_valid[i]) begin
          rsp_cyc[i] = cyc;
          rsp_n[i]++;
          err_obs[i] = bus.rsp_err;
        end
      end
      if (bus.m_write || bus.m_read) ops.push_back({bus.m_write, bus.m_addr, bus.m_write ? bus.m_writedata : 32'h0});
      idle_l = !act;
      if (act && off == done_off) begin
        act = 0;
        ptr = sel;
      end
      req_l = bus.req_valid;
      cfgv_l = bus.req_cfg;
      txv_l = bus.req_tx;
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (bus.req_ack[i] && !persist[i]) bus.req_valid[i] = 1'b0;
  endtask
  task automatic set_req(int i, logic [17:0] c, logic [31:0] t);
    bus.req_cfg[i*18 +: 18] = c;
    bus.req_tx[i*32 +: 32] = t;
  endtask
  task automatic wait_rsp(int i, int budget);
    int n0, k;
    n0 = rsp_n[i];
    k = 0;
    while (rsp_n[i] == n0 && k < budget) begin
      tick();
      k++;
    end
    check($sformatf("wait_rsp%0d", i), rsp_n[i] != n0, 1'b1);
  endtask
  task automatic wait_grants(int target, int budget);
    int k;
    k = 0;
    while (grants.size() < target && k < budget) begin
      tick();
      k++;
    end
    check("wait_grants", grants.size() >= target, 1'b1);
  endtask
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int n0, r0, r3, rn;
    bus.req_valid = '0;
    bus.req_cfg = '0;
    bus.req_tx = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("post_rst_busy", bus.busy, 1'b0);
    check("post_rst_rx", bus.rsp_rx, 32'h0);
    check("post_rst_ack", bus.req_ack, '0);
    tick();
    for (int i = 0; i < N; i++) set_req(i, 18'h00007 + 18'(i) * 18'h00100, 32'h11000000 * (i + 1));
    persist = '1;
    bus.req_valid = '1;
    wait_grants(5, 100);
    persist = '0;
    bus.req_valid = '0;
    wait_rsp(0, 40);
    check("rr_order", {grants[0][3:0], grants[1][3:0], grants[2][3:0], grants[3][3:0], grants[4][3:0]}, 20'h01230);
    check("rr_spacing", ack_q[1] - ack_q[0], 9);
    ops.delete();
    set_req(0, 18'h0FF07, 32'hA5000000);
    bus.req_valid = 4'b0001;
    n0 = grants.size();
    wait_rsp(0, 40);
    check("t1_grant", grants[n0], 0);
    check("t1_ops_n", ops.size(), 5);
    if (ops.size() == 5) begin
      check("t1_op0", ops[0], {1'b1, 3'd1, 32'h0000FF07});
      check("t1_op1", ops[1], {1'b1, 3'd2, 32'hA5000000});
      check("t1_op2", ops[2], {1'b1, 3'd0, 32'h00000001});
      check("t1_op3", ops[3], {1'b0, 3'd0, 32'h0});
      check("t1_op4", ops[4], {1'b0, 3'd3, 32'h0});
    end
    check("t1_lat", rsp_cyc[0] - ack_cyc[0], 7);
    check("t1_rx", bus.rsp_rx, 32'h000000A5);
    check("t1_err", err_obs[0], 1'b0);
    nbusy = 2;
    set_req(1, 18'h304C7, 32'h3C000000);
    bus.req_valid = 4'b0010;
    wait_rsp(1, 60);
    check("lb_rx", bus.rsp_rx[7:0], 8'h3C);
    check("lb_err", err_obs[1], 1'b0);
    check("lb_lat", rsp_cyc[1] - ack_cyc[1], 11);
    nbusy = 1;
    n0 = grants.size();
    bus.req_valid[2] = 1'b1;
    wait_grants(n0 + 1, 20);
    tick();
    tick();
    bus.req_valid[1] = 1'b1;
    wait_rsp(2, 40);
    wait_rsp(1, 40);
    check("cont_order", grants[n0 + 1], 1);
    check("cont_gap", ack_cyc[1] - rsp_cyc[2], 2);
    nbusy = 10;
    ops.delete();
    bus.req_valid = 4'b1000;
    wait_rsp(3, 60);
    r0 = 0;
    r3 = 0;
    foreach (ops[i]) begin
      if (ops[i][35:32] == 4'b0000) r0++;
      if (ops[i][35:32] == 4'b0011) r3++;
    end
    check("to_polls", r0, 3);
    check("to_rdrx", r3, 0);
    check("to_err", err_obs[3], 1'b1);
    check("to_rx", bus.rsp_rx, 32'h0);
    check("to_lat", rsp_cyc[3] - ack_cyc[3], 9);
    nbusy = 5;
    n0 = grants.size();
    rn = rsp_n[2];
    bus.req_valid = 4'b0100;
    wait_grants(n0 + 1, 20);
    for (int k = 0; k < 10 && !bus.m_read; k++) tick();
    check("mid_in_poll", bus.m_read, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_outs", {bus.busy, bus.m_read, bus.m_cs, bus.m_write, bus.req_ack, bus.rsp_valid, bus.rsp_rx}, '0);
    tick();
    tick();
    nbusy = 0;
    rst_n = 1'b1;
    bus.req_valid = 4'b1111;
    n0 = grants.size();
    wait_grants(n0 + 1, 20);
    check("mid_first_grant", grants[n0], 0);
    check("mid_no_rsp", rsp_n[2], rn);
    wait_rsp(0, 40);
    wait_rsp(1, 40);
    wait_rsp(2, 40);
    wait_rsp(3, 40);
    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
